ogpu_raster_sequencer: RTL and testbench
========================================

Name: ogpu_raster_sequencer

Overview:
Sequences the OpenGPU raster core from the HPS side. Triangle job words are written over Avalon-MM into a small command FIFO. The block issues each job to the raster core with a start/done handshake, counts completions and guards each job with a watchdog. It drives the 16-bit raster status word that feeds the raster-unit input PIO, and raises an interrupt on job completion.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, 2..4; the level must fit 3 bits)
CMD_W, 32, width of a job word
TIMEOUT, 16'hFFFF, maximum cycles in RUN before the error state (16-bit)

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  2  Avalon-MM register select
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
read  in  1  Avalon read strobe
readdata  out  32  registered read data
raster_cmd  out  CMD_W  job word presented to the raster core
raster_start  out  1  one-cycle issue pulse
raster_done  in  1  one-cycle job-complete pulse from the raster core
status_out  out  16  status word, wired to the raster-unit PIO in_port
irq  out  1  irq_pending & irq_en

Behaviour:
- Clock and reset: single clock `clk`; reset `reset_n` is asynchronous, active-low.
- Reset values: all outputs 0; FSM = IDLE; FIFO empty; enable = 0; irq_en = 0; counters = 0; err = 0; ovf = 0.
- Register map, write side:
  - addr0 pushes writedata[CMD_W-1:0] into the FIFO.
  - addr1 bit0 = enable, bit1 = irq_en, bit2 = clear (self-clearing strobe, not stored).
  - addr3 write (any data) clears irq_pending.
- Register map, read side:
  - Read latency is 1 cycle: readdata updates on the clock after address is sampled, every cycle, as with the PIO.
  - addr0 → 0.
  - addr1 → {30'b0, irq_en, enable}.
  - addr2 → {done_count[7:0], 7'b0, ovf, status_out}.
  - addr3 → {16'b0, wd_count}.
- FIFO:
  - A push updates the level at the next edge.
  - A push while full is dropped and sets sticky ovf.
  - Push and pop in the same cycle are both legal and leave the level unchanged.
  - Pushes are accepted while enable = 0; dispatch is gated by enable.
- FSM (state code in status_out[15:14]):
  - IDLE (00): when enable & !empty, go to ISSUE.
  - ISSUE (01): lasts exactly one cycle. raster_start = 1 and raster_cmd = FIFO head; the head is popped at the end of the cycle; wd_count = 0. Next state is RUN.
  - RUN (10): wd_count increments every cycle.
    - raster_done → IDLE; done_count += 1 (8-bit, wraps 255→0); irq_pending = 1.
    - Else if wd_count == TIMEOUT-1 → ERROR; err = 1.
    - raster_done in the same cycle as the timeout condition: done wins.
  - ERROR (11): hold here; raster_start stays 0; exit only via clear.
- raster_cmd holds its last issued value until the next ISSUE.
- raster_done outside RUN is ignored and does not count.
- clear, in any state:
  - Next cycle: IDLE, FIFO empty, done_count = 0, wd_count = 0, err = 0, ovf = 0, irq_pending = 0.
  - enable and irq_en take bits 0/1 of the same write.
  - A push and a clear cannot occur together (same bus); a clear during RUN abandons the job, and a later raster_done is ignored.
- irq_pending set and clear in the same cycle: set wins.
- status_out bit layout:
  - [15:14] state
  - [13] err
  - [12] full
  - [11] empty
  - [10] irq_pending
  - [9:7] FIFO level
  - [6:0] done_count[6:0]
- status_out is registered and updates with the state.

Test Plan:
- Reset: hold reset_n = 0, then release → status_out = 16'h0800 (empty), irq = 0, readdata = 0, raster_start = 0.
- Single job:
  - Stimulus: write addr1 = 3, write addr0 = 32'hCAFE0001, pulse raster_done 5 cycles after raster_start.
  - Response: raster_start high for exactly 1 cycle with raster_cmd = CAFE0001; return to IDLE; done_count = 1; irq = 1; status_out = 16'h0C01.
  - Follow-up: write addr3 → irq = 0.
- FIFO full/overflow:
  - Stimulus: enable = 0, push 5 words.
  - Response: level = 4, full = 1, ovf = 1 (addr2 bit16); 5th word lost.
  - Follow-up: set enable = 1 with prompt raster_done → 4 issues in FIFO order.
- Watchdog: TIMEOUT = 16 (sim override), no raster_done → ERROR after 16 RUN cycles, status_out[15:13] = 3'b111; a later raster_done leaves done_count unchanged; writing clear → IDLE, err = 0.
- Boundaries:
  - raster_done on the same cycle as the timeout → IDLE, done_count increments, err = 0.
  - Push on the same cycle as the ISSUE pop → level unchanged.
  - done_count wraps: 256 jobs → 0.

Source files
------------

// File: rtl/ogpu_raster_sequencer.sv
// ---------------------------------------------------------------------------
// ogpu_raster_sequencer
//
// Feeds triangle job words from the HPS (Avalon-MM slave) to the OpenGPU
// raster core. Jobs are queued in a small command FIFO and issued one at a
// time with a start/done handshake. Completions are counted, and a watchdog
// parks the sequencer in ERROR if a job runs too long. A 16-bit status word
// drives the raster-unit PIO, and an interrupt is raised on job completion.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        register select
//                       (0 push, 1 control, 2 status, 3 irq ack / watchdog)
//   write, writedata    Avalon write strobe and data
//   read                Avalon read strobe (readdata refreshes every cycle)
//   readdata[31:0]      registered read data, one cycle latency
//   raster_cmd          job word held for the raster core
//   raster_start        one-cycle issue pulse
//   raster_done         one-cycle completion pulse from the raster core
//   status_out[15:0]    {state, err, full, empty, irq_pending, level, done[6:0]}
//   irq                 irq_pending & irq_en
// ---------------------------------------------------------------------------
module ogpu_raster_sequencer #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          CMD_W      = 32,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic [CMD_W-1:0] raster_cmd,
    output logic             raster_start,
    input  logic             raster_done,
    output logic [15:0]      status_out,
    output logic             irq
);

    localparam int          PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  DEPTH_L = 3'(FIFO_DEPTH);
    localparam logic [15:0] WD_LAST = TIMEOUT - 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RUN   = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CMD_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_next_s, rd_ptr_next_s;
    logic [2:0]         level_r, level_next_s;
    logic               enable_r, enable_next_s;
    logic               irq_en_r, irq_en_next_s;
    logic               err_r, err_next_s;
    logic               ovf_r, ovf_next_s;
    logic               irq_pend_r, irq_pend_next_s;
    logic [7:0]         done_cnt_r, done_cnt_next_s;
    logic [15:0]        wd_r, wd_next_s;
    logic [15:0]        status_r, status_next_s;
    logic               raster_start_r;
    logic [CMD_W-1:0]   raster_cmd_r;
    logic               irq_r;
    logic [31:0]        readdata_r, rd_mux_s;

    logic               wr_ctrl_s, clear_s, push_req_s, irq_ack_s;
    logic               full_s, empty_s;
    logic               push_ok_s, ovf_set_s, pop_s, done_s, timeout_s;

    // readdata refreshes every cycle regardless of the read strobe
    logic               unused_read_s;
    assign unused_read_s = read;

    assign readdata     = readdata_r;
    assign raster_cmd   = raster_cmd_r;
    assign raster_start = raster_start_r;
    assign status_out   = status_r;
    assign irq          = irq_r;

    assign wr_ctrl_s  = write && (address == 2'd1);
    assign clear_s    = wr_ctrl_s && writedata[2];
    assign push_req_s = write && (address == 2'd0);
    assign irq_ack_s  = write && (address == 2'd3);
    assign full_s     = (level_r == DEPTH_L);
    assign empty_s    = (level_r == 3'd0);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; clear overrides every state
    always_comb begin
        state_next_s = state_r;
        if (clear_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable_r && !empty_s) begin
                        state_next_s = ST_ISSUE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ISSUE: state_next_s = ST_RUN;
                ST_RUN: begin
                    // completion beats the watchdog when both land together
                    if (raster_done) begin
                        state_next_s = ST_IDLE;
                    end else if (wd_r == WD_LAST) begin
                        state_next_s = ST_ERROR;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_ERROR: state_next_s = ST_ERROR;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM-derived datapath controls
    always_comb begin
        pop_s     = (state_r == ST_ISSUE) && !clear_s;
        done_s    = (state_r == ST_RUN) && raster_done && !clear_s;
        timeout_s = (state_r == ST_RUN) && !raster_done && (wd_r == WD_LAST) && !clear_s;
        // a push while full is dropped even if the same cycle pops
        push_ok_s = push_req_s && !full_s;
        ovf_set_s = push_req_s && full_s;
    end

    // next values for FIFO bookkeeping, counters and flags
    always_comb begin
        level_next_s    = level_r;
        wr_ptr_next_s   = wr_ptr_r;
        rd_ptr_next_s   = rd_ptr_r;
        done_cnt_next_s = done_cnt_r;
        wd_next_s       = wd_r;
        err_next_s      = err_r;
        ovf_next_s      = ovf_r;
        irq_pend_next_s = irq_pend_r;
        enable_next_s   = enable_r;
        irq_en_next_s   = irq_en_r;

        if (wr_ctrl_s) begin
            enable_next_s = writedata[0];
            irq_en_next_s = writedata[1];
        end else begin
            enable_next_s = enable_r;
            irq_en_next_s = irq_en_r;
        end

        if (clear_s) begin
            level_next_s    = 3'd0;
            wr_ptr_next_s   = '0;
            rd_ptr_next_s   = '0;
            done_cnt_next_s = 8'd0;
            wd_next_s       = 16'd0;
            err_next_s      = 1'b0;
            ovf_next_s      = 1'b0;
            irq_pend_next_s = 1'b0;
        end else begin
            case ({push_ok_s, pop_s})
                2'b10:   level_next_s = level_r + 3'd1;
                2'b01:   level_next_s = level_r - 3'd1;
                default: level_next_s = level_r;
            endcase
            if (push_ok_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end

            case (state_r)
                ST_ISSUE: wd_next_s = 16'd0;
                ST_RUN:   wd_next_s = wd_r + 16'd1;
                default:  wd_next_s = wd_r;
            endcase

            if (done_s) begin
                done_cnt_next_s = done_cnt_r + 8'd1;
            end else begin
                done_cnt_next_s = done_cnt_r;
            end
            if (timeout_s) begin
                err_next_s = 1'b1;
            end else begin
                err_next_s = err_r;
            end
            if (ovf_set_s) begin
                ovf_next_s = 1'b1;
            end else begin
                ovf_next_s = ovf_r;
            end
            // a completion in the same cycle as an acknowledge keeps the flag set
            if (done_s) begin
                irq_pend_next_s = 1'b1;
            end else if (irq_ack_s) begin
                irq_pend_next_s = 1'b0;
            end else begin
                irq_pend_next_s = irq_pend_r;
            end
        end

        // built from next values so the status word changes together with the state
        status_next_s = {state_next_s, err_next_s, (level_next_s == DEPTH_L),
                         (level_next_s == 3'd0), irq_pend_next_s, level_next_s,
                         done_cnt_next_s[6:0]};
    end

    // read-data mux on the current register contents
    always_comb begin
        case (address)
            2'd0:    rd_mux_s = 32'd0;
            2'd1:    rd_mux_s = {30'd0, irq_en_r, enable_r};
            2'd2:    rd_mux_s = {done_cnt_r, 7'd0, ovf_r, status_r};
            2'd3:    rd_mux_s = {16'd0, wd_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // control/status registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            level_r        <= 3'd0;
            enable_r       <= 1'b0;
            irq_en_r       <= 1'b0;
            err_r          <= 1'b0;
            ovf_r          <= 1'b0;
            irq_pend_r     <= 1'b0;
            done_cnt_r     <= 8'd0;
            wd_r           <= 16'd0;
            status_r       <= 16'd0;
            raster_start_r <= 1'b0;
            raster_cmd_r   <= '0;
            irq_r          <= 1'b0;
            readdata_r     <= 32'd0;
        end else begin
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            level_r        <= level_next_s;
            enable_r       <= enable_next_s;
            irq_en_r       <= irq_en_next_s;
            err_r          <= err_next_s;
            ovf_r          <= ovf_next_s;
            irq_pend_r     <= irq_pend_next_s;
            done_cnt_r     <= done_cnt_next_s;
            wd_r           <= wd_next_s;
            status_r       <= status_next_s;
            raster_start_r <= (state_next_s == ST_ISSUE);
            // the head cannot change while non-empty, so it is latched on ISSUE entry
            if (state_next_s == ST_ISSUE) begin
                raster_cmd_r <= mem_r[rd_ptr_r];
            end else begin
                raster_cmd_r <= raster_cmd_r;
            end
            irq_r          <= irq_pend_next_s & irq_en_next_s;
            readdata_r     <= rd_mux_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s && !clear_s) begin
                mem_r[wr_ptr_r] <= writedata[CMD_W-1:0];
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
        end
    end

endmodule

// File: tb/tb_ogpu_raster_sequencer.sv
module tb_ogpu_raster_sequencer;

    localparam int          DEPTH = 4;
    localparam logic [15:0] TMO   = 16'd16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic [31:0] raster_cmd;
    logic        raster_start;
    logic        raster_done = 1'b0;
    logic [15:0] status_out;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    ogpu_raster_sequencer #(.FIFO_DEPTH(DEPTH), .CMD_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .raster_cmd(raster_cmd), .raster_start(raster_start),
        .raster_done(raster_done), .status_out(status_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (queue + rule-level bookkeeping) -------
    int          m_phase;   // 0 idle, 1 issue, 2 run, 3 error
    logic [31:0] m_q[$];
    bit          m_en, m_ien, m_err, m_ovf, m_pend;
    int          m_done;
    int          m_wd;
    logic [31:0] m_cmd;

    function automatic logic [15:0] m_status();
        int lvl;
        lvl = m_q.size();
        return {2'(m_phase), m_err, (lvl == DEPTH), (lvl == 0), m_pend,
                3'(lvl), 7'(m_done)};
    endfunction

    task automatic m_step(input logic w, input logic [1:0] a, input logic [31:0] d,
                          input logic dn, output logic [31:0] rd_exp);
        int sz;
        int old;
        bit done_ev;
        sz = m_q.size();
        done_ev = 1'b0;
        case (a)
            2'd0: rd_exp = 32'd0;
            2'd1: rd_exp = {30'd0, m_ien, m_en};
            2'd2: rd_exp = {8'(m_done), 7'd0, m_ovf, m_status()};
            default: rd_exp = {16'd0, 16'(m_wd)};
        endcase
        if (w && a == 2'd1 && d[2]) begin
            m_phase = 0; m_q.delete(); m_done = 0; m_wd = 0;
            m_err = 1'b0; m_ovf = 1'b0; m_pend = 1'b0;
            m_en = d[0]; m_ien = d[1];
        end else begin
            if (m_phase == 1) void'(m_q.pop_front());
            if (w && a == 2'd0) begin
                if (sz == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(d);
            end
            case (m_phase)
                0: if (m_en && sz > 0) begin m_phase = 1; m_cmd = m_q[0]; end
                1: begin m_phase = 2; m_wd = 0; end
                2: begin
                    old = m_wd;
                    m_wd = m_wd + 1;
                    if (dn) begin
                        m_phase = 0; m_done = (m_done + 1) % 256; done_ev = 1'b1;
                    end else if (old == int'(TMO) - 1) begin
                        m_phase = 3; m_err = 1'b1;
                    end
                end
                default: ;
            endcase
            if (done_ev) m_pend = 1'b1;
            else if (w && a == 2'd3) m_pend = 1'b0;
            if (w && a == 2'd1) begin m_en = d[0]; m_ien = d[1]; end
        end
    endtask

    // ---------------- helpers -------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d, input logic dn);
        logic [31:0] rd_exp;
        write = w; address = a; writedata = d; raster_done = dn; read = ~w;
        m_step(w, a, d, dn, rd_exp);
        @(posedge clk);
        #1;
        check("status", {16'd0, status_out}, {16'd0, m_status()});
        check("irq", {31'd0, irq}, {31'd0, (m_pend & m_ien)});
        check("start", {31'd0, raster_start}, {31'd0, (m_phase == 1)});
        check("cmd", raster_cmd, m_cmd);
        check("readdata", readdata, rd_exp);
        write = 1'b0; raster_done = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int limit);
        int k;
        k = 0;
        while (status_out[15:14] != st && k < limit) begin
            cyc(1'b0, 2'd2, 32'd0, 1'b0);
            k++;
        end
        check("wait_state", {30'd0, status_out[15:14]}, {30'd0, st});
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b0, 2'd2, 32'd0, status_out[15:14] == 2'b10);
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic        dn;
        logic [15:0] st;
        logic        start;
        logic        irq;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] got[$];
    int          k;
    logic        w_r;
    logic [1:0]  a_r;
    logic [31:0] d_r;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // single job: enable, push, issue, done five cycles after start, ack
        tbl[0] = '{1'b1, 2'd1, 32'd3,          1'b0, 16'h0800, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'd0, 32'hCAFE0001,   1'b0, 16'h0080, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'd2, 32'd0,          1'b0, 16'h4080, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 2'd2, 32'd0,          1'b0, 16'h8800, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'd2, 32'd0,          1'b0, 16'h8800, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2'd2, 32'd0,          1'b0, 16'h8800, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 2'd2, 32'd0,          1'b0, 16'h8800, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 2'd2, 32'd0,          1'b1, 16'h0C01, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 2'd3, 32'd0,          1'b0, 16'h0801, 1'b0, 1'b0};

        m_phase = 0; m_q.delete(); m_en = 1'b0; m_ien = 1'b0; m_err = 1'b0;
        m_ovf = 1'b0; m_pend = 1'b0; m_done = 0; m_wd = 0; m_cmd = 32'd0;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_status", {16'd0, status_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_start", {31'd0, raster_start}, 32'd0);
        cyc(1'b0, 2'd0, 32'd0, 1'b0);
        check("idle_status", {16'd0, status_out}, 32'h0000_0800);

        // table-driven single job
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].dn);
            check($sformatf("tbl%0d_status", i), {16'd0, status_out}, {16'd0, tbl[i].st});
            check($sformatf("tbl%0d_start", i), {31'd0, raster_start}, {31'd0, tbl[i].start});
            check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
            if (i == 2) check("tbl_cmd", raster_cmd, 32'hCAFE0001);
        end

        // FIFO full / overflow with dispatch disabled
        cyc(1'b1, 2'd1, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 32'h1000_0000 + i, 1'b0);
        check("full_status", {16'd0, status_out}, 32'h0000_1201);
        cyc(1'b0, 2'd2, 32'd0, 1'b0);
        check("ovf_readback", readdata, 32'h0101_1201);
        cyc(1'b1, 2'd1, 32'd1, 1'b0);
        got.delete();
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 2'd2, 32'd0, status_out[15:14] == 2'b10);
            if (raster_start) got.push_back(raster_cmd);
        end
        check("issue_count", got.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) check($sformatf("issue_order%0d", i), got[i], 32'h1000_0000 + i);
        end

        // watchdog expiry, done ignored in ERROR, clear
        cyc(1'b1, 2'd0, 32'hDEAD0001, 1'b0);
        wait_state(2'b10, 10);
        k = 0;
        while (status_out[15:14] != 2'b11 && k < 40) begin
            cyc(1'b0, 2'd2, 32'd0, 1'b0);
            k++;
        end
        check("wd_run_cycles", k, 32'd16);
        check("err_state", {29'd0, status_out[15:13]}, 32'd7);
        cyc(1'b0, 2'd3, 32'd0, 1'b0);
        check("wd_readback", readdata, 32'd16);
        cyc(1'b0, 2'd2, 32'd0, 1'b1);
        check("done_in_error", {25'd0, status_out[6:0]}, 32'd5);
        cyc(1'b1, 2'd1, 32'd7, 1'b0);
        check("clear_status", {16'd0, status_out}, 32'h0000_0800);

        // done on the same cycle as the timeout
        cyc(1'b1, 2'd0, 32'hBEEF0002, 1'b0);
        wait_state(2'b10, 10);
        for (int i = 0; i < 15; i++) cyc(1'b0, 2'd2, 32'd0, 1'b0);
        cyc(1'b0, 2'd2, 32'd0, 1'b1);
        check("race_state", {30'd0, status_out[15:14]}, 32'd0);
        check("race_err", {31'd0, status_out[13]}, 32'd0);
        check("race_done", {25'd0, status_out[6:0]}, 32'd1);

        // push in the ISSUE cycle keeps the level
        cyc(1'b1, 2'd0, 32'hA0A0_0001, 1'b0);
        cyc(1'b1, 2'd0, 32'hA0A0_0002, 1'b0);
        check("pre_issue_state", {30'd0, status_out[15:14]}, 32'd1);
        check("pre_issue_level", {29'd0, status_out[9:7]}, 32'd2);
        cyc(1'b1, 2'd0, 32'hA0A0_0003, 1'b0);
        check("issue_push_level", {29'd0, status_out[9:7]}, 32'd2);
        drain(30);

        // done_count wraps after 256 jobs
        cyc(1'b1, 2'd1, 32'd7, 1'b0);
        for (int j = 0; j < 256; j++) begin
            cyc(1'b1, 2'd0, 32'h5000_0000 + j, 1'b0);
            wait_state(2'b10, 10);
            cyc(1'b0, 2'd2, 32'd0, 1'b1);
            if (j == 254) begin
                cyc(1'b0, 2'd2, 32'd0, 1'b0);
                check("done_255", {24'd0, readdata[31:24]}, 32'd255);
            end
        end
        cyc(1'b0, 2'd2, 32'd0, 1'b0);
        check("wrap_readback", {24'd0, readdata[31:24]}, 32'd0);
        check("wrap_status", {25'd0, status_out[6:0]}, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            w_r = ($urandom_range(0, 3) == 0);
            a_r = 2'($urandom_range(0, 3));
            d_r = $urandom;
            if (w_r && a_r == 2'd1) begin
                d_r[2] = ($urandom_range(0, 15) == 0);
                d_r[0] = ($urandom_range(0, 3) != 0);
            end
            cyc(w_r, a_r, d_r, $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
